// File: rtl/dd_bus_arbiter.sv
// dd_bus_arbiter
//   Three-way round-robin arbiter for the DD bus (CPU, blitter, fill source).
//   A granted owner keeps the bus for up to MAXBURST consecutive cycles.
//   Every loss of ownership passes through a one-cycle TURN with no owner.
//   The fill source has no external grant. When it owns the bus, this block
//   drives DD_0..DD_6 itself through the outDD_n/enDD_n tristate pairs.
//
// Ports
//   CLK, RESET            clock, synchronous active-high reset
//   REQ_CPU/BLT/FILL      level-sensitive bus requests
//   FILL_0..FILL_6        fill value placed on DD_0..DD_6 while fill owns
//   GNT_CPU, GNT_BLT      registered grants to the external drivers
//   outDD_n, enDD_n       fill tristate data/enable for DD_n
//   BUSY                  high whenever the FSM is not IDLE
module dd_bus_arbiter #(
   parameter int MAXBURST = 8
) (
   input  logic CLK,
   input  logic RESET,
   input  logic REQ_CPU,
   input  logic REQ_BLT,
   input  logic REQ_FILL,
   input  logic FILL_0,
   input  logic FILL_1,
   input  logic FILL_2,
   input  logic FILL_3,
   input  logic FILL_4,
   input  logic FILL_5,
   input  logic FILL_6,
   output logic GNT_CPU,
   output logic GNT_BLT,
   output logic outDD_0,
   output logic outDD_1,
   output logic outDD_2,
   output logic outDD_3,
   output logic outDD_4,
   output logic outDD_5,
   output logic outDD_6,
   output logic enDD_0,
   output logic enDD_1,
   output logic enDD_2,
   output logic enDD_3,
   output logic enDD_4,
   output logic enDD_5,
   output logic enDD_6,
   output logic BUSY
);

   localparam int         DD_W    = 7;
   localparam logic [3:0] MAX_CNT = 4'(MAXBURST);

   typedef enum logic [1:0] {IDLE, OWN, TURN} state_t;
   typedef enum logic [1:0] {SRC_CPU, SRC_BLT, SRC_FILL} src_t;

   // One-hot source vectors: bit0 CPU, bit1 BLT, bit2 FILL
   state_t     state, nextState;
   src_t       lastOwner, nextLast;
   logic [2:0] reqVec, gnt, nextGnt, pick;
   logic [3:0] burstCnt, nextCnt;
   logic [DD_W-1:0] fillVec, outVec;

   assign reqVec = {REQ_FILL, REQ_BLT, REQ_CPU};

   // Search begins at the source after the last owner. The last owner is
   // therefore checked last. A lone repeat requester is still re-granted.
   function automatic logic [2:0] rrPick(input logic [2:0] req, input src_t last);
      logic [2:0] p;
      p = 3'b000;
      case (last)
         SRC_CPU:  if (req[1]) p = 3'b010; else if (req[2]) p = 3'b100; else if (req[0]) p = 3'b001;
         SRC_BLT:  if (req[2]) p = 3'b100; else if (req[0]) p = 3'b001; else if (req[1]) p = 3'b010;
         default:  if (req[0]) p = 3'b001; else if (req[1]) p = 3'b010; else if (req[2]) p = 3'b100;
      endcase
      return p;
   endfunction

   function automatic src_t srcOf(input logic [2:0] oneHot);
      src_t s;
      if (oneHot[0])      s = SRC_CPU;
      else if (oneHot[1]) s = SRC_BLT;
      else                s = SRC_FILL;
      return s;
   endfunction

   always_comb begin
      nextState = state;
      nextGnt   = gnt;
      nextCnt   = burstCnt;
      nextLast  = lastOwner;
      pick      = rrPick(reqVec, lastOwner);
      case (state)
         IDLE, TURN: begin
            if (|reqVec) begin
               nextState = OWN;
               nextGnt   = pick;
               nextCnt   = 4'd1;
               nextLast  = srcOf(pick);
            end else begin
               nextState = IDLE;
               nextGnt   = 3'b000;
            end
         end
         OWN: begin
            // Leave when the owner releases or its burst is used up. The grant
            // drops on the same edge, so TURN never shows an owner.
            if (|(reqVec & gnt) && (burstCnt < MAX_CNT)) begin
               nextCnt = burstCnt + 4'd1;
            end else begin
               nextState = TURN;
               nextGnt   = 3'b000;
            end
         end
         default: begin
            nextState = IDLE;
            nextGnt   = 3'b000;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state     <= IDLE;
         gnt       <= 3'b000;
         burstCnt  <= 4'd0;
         lastOwner <= SRC_FILL;   // CPU is the first winner
      end else begin
         state     <= nextState;
         gnt       <= nextGnt;
         burstCnt  <= nextCnt;
         lastOwner <= nextLast;
      end
   end

   assign GNT_CPU = gnt[0];
   assign GNT_BLT = gnt[1];
   assign BUSY    = (state != IDLE);

   // The fill data path is combinational from FILL_n. A change in the fill
   // value shows up on DD in the same cycle.
   assign fillVec = {FILL_6, FILL_5, FILL_4, FILL_3, FILL_2, FILL_1, FILL_0};
   assign outVec  = fillVec & {DD_W{gnt[2]}};

   assign {outDD_6, outDD_5, outDD_4, outDD_3, outDD_2, outDD_1, outDD_0} = outVec;
   assign {enDD_6, enDD_5, enDD_4, enDD_3, enDD_2, enDD_1, enDD_0} = {DD_W{gnt[2]}};

endmodule

// File: tb/tb_dd_bus_arbiter.sv
// Directed and randomized checks for dd_bus_arbiter with MAXBURST=8.
// Inputs are driven and outputs are sampled on the falling clock edge.
module tb_dd_bus_arbiter;

   logic CLK = 1'b0;
   logic RESET, REQ_CPU, REQ_BLT, REQ_FILL;
   logic [6:0] fillVal;
   logic GNT_CPU, GNT_BLT, BUSY;
   logic outDD_0, outDD_1, outDD_2, outDD_3, outDD_4, outDD_5, outDD_6;
   logic enDD_0, enDD_1, enDD_2, enDD_3, enDD_4, enDD_5, enDD_6;
   logic [6:0] outVec, enVec;
   logic [2:0] gntObs;   // {cpu, blt, fill}

   int tests = 0;
   int fails = 0;

   always #5 CLK = ~CLK;

   dd_bus_arbiter #(.MAXBURST(8)) dut (
      .CLK(CLK), .RESET(RESET),
      .REQ_CPU(REQ_CPU), .REQ_BLT(REQ_BLT), .REQ_FILL(REQ_FILL),
      .FILL_0(fillVal[0]), .FILL_1(fillVal[1]), .FILL_2(fillVal[2]), .FILL_3(fillVal[3]),
      .FILL_4(fillVal[4]), .FILL_5(fillVal[5]), .FILL_6(fillVal[6]),
      .GNT_CPU(GNT_CPU), .GNT_BLT(GNT_BLT),
      .outDD_0(outDD_0), .outDD_1(outDD_1), .outDD_2(outDD_2), .outDD_3(outDD_3),
      .outDD_4(outDD_4), .outDD_5(outDD_5), .outDD_6(outDD_6),
      .enDD_0(enDD_0), .enDD_1(enDD_1), .enDD_2(enDD_2), .enDD_3(enDD_3),
      .enDD_4(enDD_4), .enDD_5(enDD_5), .enDD_6(enDD_6),
      .BUSY(BUSY)
   );

   assign outVec = {outDD_6, outDD_5, outDD_4, outDD_3, outDD_2, outDD_1, outDD_0};
   assign enVec  = {enDD_6, enDD_5, enDD_4, enDD_3, enDD_2, enDD_1, enDD_0};
   assign gntObs = {GNT_CPU, GNT_BLT, enDD_0};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge CLK);
   endtask

   logic [2:0] req, prevOwn;
   int waitCnt [3];

   initial begin
      RESET = 1'b1; REQ_CPU = 1'b0; REQ_BLT = 1'b0; REQ_FILL = 1'b0; fillVal = 7'h00;
      step(2);
      chk("rst_gnt",  32'(gntObs), 32'd0);
      chk("rst_busy", 32'(BUSY),   32'd0);
      chk("rst_out",  32'(outVec), 32'd0);
      chk("rst_en",   32'(enVec),  32'd0);

      // All three requesting: CPU 8, TURN, BLT 8, TURN, FILL
      RESET = 1'b0; fillVal = 7'h7F;
      REQ_CPU = 1'b1; REQ_BLT = 1'b1; REQ_FILL = 1'b1;
      for (int i = 0; i < 8; i++) begin step(1); chk("rr_cpu", 32'(gntObs), 32'b100); end
      step(1); chk("rr_turn1", 32'(gntObs), 32'd0); chk("rr_turn1_busy", 32'(BUSY), 32'd1);
      for (int i = 0; i < 8; i++) begin step(1); chk("rr_blt", 32'(gntObs), 32'b010); end
      step(1); chk("rr_turn2", 32'(gntObs), 32'd0);
      step(1); chk("rr_fill", 32'(gntObs), 32'b001);
      chk("rr_fill_en",  32'(enVec),  32'h7F);
      chk("rr_fill_out", 32'(outVec), 32'h7F);
      REQ_CPU = 1'b0; REQ_BLT = 1'b0; REQ_FILL = 1'b0;
      step(1); chk("rr_end_turn", 32'(gntObs), 32'd0); chk("rr_end_busy", 32'(BUSY), 32'd1);
      step(1); chk("rr_idle_busy", 32'(BUSY), 32'd0);

      // Fill alone; data follows FILL_n combinationally
      RESET = 1'b1; step(1);
      RESET = 1'b0; REQ_FILL = 1'b1; fillVal = 7'h55;
      step(1); chk("fill_out55", 32'(outVec), 32'h55); chk("fill_en", 32'(enVec), 32'h7F);
      fillVal = 7'h2A; #1;
      chk("fill_out2A", 32'(outVec), 32'h2A);
      REQ_FILL = 1'b0;
      step(1); chk("fill_turn_en", 32'(enVec), 32'd0);
      step(1); chk("fill_idle", 32'(BUSY), 32'd0);

      // BLT for three cycles, then release
      REQ_BLT = 1'b1;
      step(1); chk("blt_c1", 32'(gntObs), 32'b010);
      step(1); chk("blt_c2", 32'(gntObs), 32'b010);
      step(1); chk("blt_c3", 32'(gntObs), 32'b010);
      REQ_BLT = 1'b0;
      step(1); chk("blt_turn", 32'(gntObs), 32'd0); chk("blt_turn_busy", 32'(BUSY), 32'd1);
      step(1); chk("blt_idle", 32'(BUSY), 32'd0);

      // CPU alone for 20 cycles: 8 on, 1 off, 8 on, 1 off, on
      REQ_CPU = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step(1);
         chk("cpu_burst", 32'(GNT_CPU), (i == 8 || i == 17) ? 32'd0 : 32'd1);
      end
      REQ_CPU = 1'b0;
      step(2); chk("cpu_idle", 32'(BUSY), 32'd0);

      // Reset during the fourth owned cycle of FILL
      REQ_FILL = 1'b1; fillVal = 7'h55;
      step(1); chk("rstmid_own", 32'(gntObs), 32'b001);
      step(3); chk("rstmid_c4", 32'(enVec), 32'h7F);
      RESET = 1'b1; REQ_CPU = 1'b1;
      step(1);
      chk("rstmid_gnt",  32'(gntObs), 32'd0);
      chk("rstmid_out",  32'(outVec), 32'd0);
      chk("rstmid_en",   32'(enVec),  32'd0);
      chk("rstmid_busy", 32'(BUSY),   32'd0);
      RESET = 1'b0;
      step(1); chk("rstmid_cpu_first", 32'(gntObs), 32'b100);

      // Random requests. A request is held until it has been granted.
      RESET = 1'b1; REQ_CPU = 1'b0; REQ_BLT = 1'b0; REQ_FILL = 1'b0;
      step(1);
      RESET = 1'b0;
      req = 3'b000; prevOwn = 3'b000;
      for (int k = 0; k < 3; k++) waitCnt[k] = 0;
      for (int c = 0; c < 10000; c++) begin
         {REQ_CPU, REQ_BLT, REQ_FILL} = req;
         step(1);
         chk("rnd_mutex", 32'($countones(gntObs) <= 1), 32'd1);
         chk("rnd_data",  32'(outVec), 32'(fillVal & {7{gntObs[0]}}));
         chk("rnd_en",    32'(enVec),  32'({7{gntObs[0]}}));
         if (prevOwn != 3'b000 && gntObs != 3'b000)
            chk("rnd_turn", 32'(gntObs), 32'(prevOwn));
         prevOwn = gntObs;
         for (int k = 0; k < 3; k++) begin
            if (req[k] && !gntObs[k]) waitCnt[k]++;
            else                      waitCnt[k] = 0;
            chk("rnd_latency", 32'(waitCnt[k] <= 19), 32'd1);
            if (req[k] && gntObs[k] && $urandom_range(0, 3) == 0) req[k] = 1'b0;
            else if (!req[k] && $urandom_range(0, 2) == 0)      req[k] = 1'b1;
         end
         if ($urandom_range(0, 7) == 0) fillVal = 7'($urandom);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
